// File: rtl/sram_1k8_sp_pkg.sv
// rtl/sram_1k8_sp_pkg.sv - shared constants, types and helpers for the 1Kx8 single-port RAM
package sram_1k8_sp_pkg;

  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DEPTH  = 1024;

  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
  typedef logic [RAM_DATA_W-1:0] ram_data_t;

  // Callers zero-extend their address to 32 bits so one helper serves any ADDR_W.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/sram_1k8_sp_if.sv
// rtl/sram_1k8_sp_if.sv - request/response bus between a simple master and the RAM
interface sram_1k8_sp_if
  import sram_1k8_sp_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);

  logic              cs;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (
    output cs,
    output wr,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  cs,
    input  wr,
    input  addr,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/sram_vld_map.sv
// rtl/sram_vld_map.sv - per-word valid bits; reset clears them all at once so stale array words read as zero
module sram_vld_map
  import sram_1k8_sp_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] look_addr,
  output logic              look_hit
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic             set_ok;
  logic             look_ok;

  assign set_ok  = addr_in_range(32'(set_addr), DEPTH);
  assign look_ok = addr_in_range(32'(look_addr), DEPTH);

  always_comb begin
    vld_d = vld_q;
    if (set_en && set_ok) begin
      vld_d[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Out-of-range lookups never index the vector.
  assign look_hit = look_ok ? vld_q[look_addr] : 1'b0;

endmodule

// File: rtl/sram_1k8_sp.sv
// rtl/sram_1k8_sp.sv - single-port synchronous RAM with registered read and valid-masked reset
module sram_1k8_sp
  import sram_1k8_sp_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_1k8_sp_if.slave  bus
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              in_range;
  logic              wr_en;
  logic              rd_en;
  logic              hit;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;

  assign in_range = addr_in_range(32'(bus.addr), DEPTH);
  // rst_n gates the write so an edge that lands during reset cannot commit.
  assign wr_en    = bus.cs && bus.wr && in_range && rst_n;
  assign rd_en    = bus.cs && !bus.wr;

  sram_vld_map #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_vld (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (wr_en),
    .set_addr  (bus.addr),
    .look_addr (bus.addr),
    .look_hit  (hit)
  );

  // Plain write port with no reset keeps the array mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[bus.addr] <= bus.data_in;
    end
  end

  assign rd_word = (in_range && hit) ? mem[bus.addr] : '0;

  always_comb begin
    data_out_d = data_out_q;
    if (rd_en) begin
      data_out_d = rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_sram_1k8_sp.sv
// tb/tb_sram_1k8_sp.sv - directed self-checking bench for sram_1k8_sp
module tb_sram_1k8_sp;
  import sram_1k8_sp_pkg::*;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  sram_1k8_sp_if #(.ADDR_W(10), .DATA_W(8)) b1 ();
  sram_1k8_sp_if #(.ADDR_W(10), .DATA_W(8)) b2 ();

  sram_1k8_sp #(.DATA_W(8), .ADDR_W(10), .DEPTH(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  sram_1k8_sp #(.DATA_W(8), .ADDR_W(10), .DEPTH(1000)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] wa [5];
  logic [7:0] wd [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [9:0] a, input logic [7:0] d);
    b1.cs = 1'b1; b1.wr = 1'b1; b1.addr = a; b1.data_in = d;
    tick();
  endtask

  task automatic rd1(input logic [9:0] a);
    b1.cs = 1'b1; b1.wr = 1'b0; b1.addr = a;
    tick();
  endtask

  task automatic test_reset();
    logic [9:0] ra [3];
    ra[0] = 10'd0; ra[1] = 10'd32; ra[2] = 10'd1023;
    tests_run++;
    if (b1.data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data_out got %h want 00", b1.data_out);
    end
    for (int i = 0; i < 3; i++) begin
      rd1(ra[i]);
      tests_run++;
      if (b1.data_out !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_read addr=%0d got %h want 00", ra[i], b1.data_out);
      end
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 5; i++) begin
      wr1(wa[i], wd[i]);
      tests_run++;
      if (b1.data_out !== 8'h00) begin
        tests_failed++;
        $display("FAIL write_hold addr=%0d got %h want 00", wa[i], b1.data_out);
      end
    end
    for (int i = 0; i < 5; i++) begin
      rd1(wa[i]);
      tests_run++;
      if (b1.data_out !== wd[i]) begin
        tests_failed++;
        $display("FAIL readback addr=%0d got %h want %h", wa[i], b1.data_out, wd[i]);
      end
      tests_run++;
      if (dut.mem[wa[i]] !== wd[i]) begin
        tests_failed++;
        $display("FAIL mem_content addr=%0d got %h want %h", wa[i], dut.mem[wa[i]], wd[i]);
      end
    end
  endtask

  task automatic test_cs_idle();
    b1.cs = 1'b0; b1.wr = 1'b1; b1.addr = 10'd32; b1.data_in = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (b1.data_out !== 8'h7F) begin
        tests_failed++;
        $display("FAIL idle_hold cycle=%0d got %h want 7f", i, b1.data_out);
      end
    end
    tests_run++;
    if (dut.mem[32] !== 8'hFF) begin
      tests_failed++;
      $display("FAIL idle_mem got %h want ff", dut.mem[32]);
    end
    rd1(10'd32);
    tests_run++;
    if (b1.data_out !== 8'hFF) begin
      tests_failed++;
      $display("FAIL idle_read got %h want ff", b1.data_out);
    end
  endtask

  task automatic test_back_to_back();
    rd1(10'd64);
    tests_run++;
    if (b1.data_out !== 8'hAC) begin
      tests_failed++;
      $display("FAIL b2b_pre_read got %h want ac", b1.data_out);
    end
    wr1(10'd100, 8'h3C);
    tests_run++;
    if (b1.data_out !== 8'hAC) begin
      tests_failed++;
      $display("FAIL b2b_write_hold got %h want ac", b1.data_out);
    end
    rd1(10'd100);
    tests_run++;
    if (b1.data_out !== 8'h3C) begin
      tests_failed++;
      $display("FAIL b2b_read got %h want 3c", b1.data_out);
    end
    rd1(10'd128);
    tests_run++;
    if (b1.data_out !== 8'h9B) begin
      tests_failed++;
      $display("FAIL b2b_read_next got %h want 9b", b1.data_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] ra [4];
    ra[0] = 10'd32; ra[1] = 10'd64; ra[2] = 10'd512; ra[3] = 10'd200;
    b1.cs = 1'b1; b1.wr = 1'b1; b1.addr = 10'd200; b1.data_in = 8'hEE;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (b1.data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL midreset_async got %h want 00", b1.data_out);
    end
    tick();
    b1.cs = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      rd1(ra[i]);
      tests_run++;
      if (b1.data_out !== 8'h00) begin
        tests_failed++;
        $display("FAIL midreset_read addr=%0d got %h want 00", ra[i], b1.data_out);
      end
    end
    wr1(10'd64, 8'hA5);
    rd1(10'd64);
    tests_run++;
    if (b1.data_out !== 8'hA5) begin
      tests_failed++;
      $display("FAIL midreset_rewrite got %h want a5", b1.data_out);
    end
    b1.cs = 1'b0;
  endtask

  task automatic test_out_of_range();
    b2.cs = 1'b1; b2.wr = 1'b1; b2.addr = 10'd999; b2.data_in = 8'h22;
    tick();
    b2.addr = 10'd10; b2.data_in = 8'h33;
    tick();
    b2.addr = 10'd1010; b2.data_in = 8'h11;
    tick();
    b2.wr = 1'b0; b2.addr = 10'd999;
    tick();
    tests_run++;
    if (b2.data_out !== 8'h22) begin
      tests_failed++;
      $display("FAIL oob_last_word got %h want 22", b2.data_out);
    end
    b2.addr = 10'd1010;
    tick();
    tests_run++;
    if (b2.data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL oob_read got %h want 00", b2.data_out);
    end
    tests_run++;
    if (dut_small.mem[999] !== 8'h22) begin
      tests_failed++;
      $display("FAIL oob_mem999 got %h want 22", dut_small.mem[999]);
    end
    tests_run++;
    if (dut_small.mem[10] !== 8'h33) begin
      tests_failed++;
      $display("FAIL oob_mem10 got %h want 33", dut_small.mem[10]);
    end
    b2.addr = 10'd10;
    tick();
    tests_run++;
    if (b2.data_out !== 8'h33) begin
      tests_failed++;
      $display("FAIL oob_read10 got %h want 33", b2.data_out);
    end
    b2.cs = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    wa[0] = 10'd32;  wd[0] = 8'hFF;
    wa[1] = 10'd64;  wd[1] = 8'hAC;
    wa[2] = 10'd128; wd[2] = 8'h9B;
    wa[3] = 10'd256; wd[3] = 8'h8F;
    wa[4] = 10'd512; wd[4] = 8'h7F;
    b1.cs = 1'b0; b1.wr = 1'b0; b1.addr = '0; b1.data_in = '0;
    b2.cs = 1'b0; b2.wr = 1'b0; b2.addr = '0; b2.data_in = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_cs_idle();
    test_back_to_back();
    test_reset_mid();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout after 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/sram_1k8_sp.md
Name: sram_1k8_sp

Overview:
- Single-port synchronous RAM, 1024 x 8 by default, with chip select and a write strobe.
- Used as a general scratch/data store behind a simple bus master.
- Writes commit on the clock edge; reads return registered data one cycle after the request.
- Reset logically clears the whole array through a per-word valid map, without a 1024-cycle clear sequence.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 10, address width in bits.
- DEPTH, 1024, number of words; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  chip select; no access occurs when low.
- wr  input  1  1 = write, 0 = read; qualified by cs.
- addr  input  ADDR_W  word address.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.

Behaviour:
- Storage is an array named mem[0:DEPTH-1] of DATA_W bits, indexable by address so benches can inspect it hierarchically. There is also a DEPTH-bit valid map, vld.
- Reset (rst_n = 0, asynchronous assert, synchronous release on the next clk edge after deassertion):
  - data_out = 0.
  - vld = all zeros.
  - mem contents are not cleared; they are stale but masked by vld.
- Write (cs=1, wr=1, addr < DEPTH) at a rising edge:
  - mem[addr] <= data_in and vld[addr] <= 1.
  - data_out holds its previous value; no write-through.
- Read (cs=1, wr=0) at a rising edge:
  - data_out <= (addr < DEPTH && vld[addr]) ? mem[addr] : 0.
  - Latency is exactly 1 cycle: data_out is valid after the edge that sampled the request.
- Idle (cs=0): no state change; data_out holds.
- Out-of-range address (addr ≥ DEPTH, possible only when DEPTH < 2**ADDR_W):
  - Writes are ignored.
  - Reads return 0.
- Back-to-back accesses are allowed every cycle, in any mix of reads and writes.
  - A read in the cycle after a write to the same address returns the new data.
- Reset asserted mid-operation:
  - Any write on the same edge is lost.
  - data_out goes to 0 immediately.
  - Every word reads 0 until rewritten.
- X on cs or wr is a bench error and is not required to be handled.
- Array inference: a single synchronous write port and a single synchronous read port, suitable for block RAM. vld is flops.

Decomposition:
- Shared package holds:
  - default constants RAM_DATA_W=8, RAM_ADDR_W=10, RAM_DEPTH=1024;
  - typedefs ram_addr_t and ram_data_t.
- One sub-module is natural: sram_vld_map. It holds the DEPTH-bit valid register with async clear, a set-on-write port and a lookup port.
- The array and data_out register stay in the top module.

Test Plan:
- Reset, then cs=1 wr=0 reads at addr 0, 32 and 1023 -> data_out = 8'h00 one cycle after each read.
- Write FF@32, AC@64, 9B@128, 8F@256, 7F@512 on consecutive cycles, then read each back -> data_out = FF, AC, 9B, 8F, 7F, each one cycle after its read, and mem[a] matches the same values.
- cs=0, wr=1, addr=32, data_in=8'h55, then read 32 -> data_out = FF (the write is ignored); data_out stays stable while cs=0.
- Write 8'h3C@100, then read 100 on the very next cycle -> data_out = 3C. During the write cycle data_out keeps its previous value.
- After the write pattern above, pulse rst_n low asynchronously mid-cycle -> data_out = 00 immediately. Subsequent reads of 32, 64 and 512 return 00; rewrite 8'hA5@64 -> reads back A5.
- With DEPTH=1000: write 8'h11@1010, then read 1010 -> data_out = 00, and mem is unchanged.
